// File: rtl/lane_scatter_pkg.sv
// Shared types and grid helpers for the lane scatter/gather block.
// The coordinate map is the inverse of the team's index-to-(i,j) mapping.
package lane_scatter_pkg;

   localparam int GRID  = 5;
   localparam int LANES = 25;
   localparam int IDX_W = 5;

   typedef enum logic {FILL, DRAIN} state_t;

   // Operands never exceed 7 after the +2 offset wraps in 3 bits, so one subtraction suffices.
   function automatic logic [2:0] mod_grid(input logic [2:0] v);
      return (v >= 3'(GRID)) ? v - 3'(GRID) : v;
   endfunction

   function automatic logic [IDX_W-1:0] ij_to_idx(input logic [2:0] i, input logic [2:0] j);
      logic [2:0] row;
      logic [2:0] col;
      row = mod_grid(j + 3'd2);
      col = mod_grid(i + 3'd2);
      return IDX_W'(row) * IDX_W'(GRID) + IDX_W'(col);
   endfunction

endpackage

// File: rtl/ij_to_index.sv
// Combinational (i,j) -> linear lane index conversion with a legality flag.
module ij_to_index
   import lane_scatter_pkg::*;
(
   input  logic [2:0]       i,
   input  logic [2:0]       j,
   output logic [IDX_W-1:0] idx,
   output logic             legal
);

   assign idx   = ij_to_idx(i, j);
   assign legal = (i < 3'(GRID)) && (j < 3'(GRID));

endmodule

// File: rtl/lane_scatter_gather.sv
// Collects 25 lanes addressed by (i,j) in any order, then streams them out in linear order.
// Define LANE_SCATTER_ERR_EN to enable the sticky err flag for illegal or duplicate writes.
module lane_scatter_gather
   import lane_scatter_pkg::*;
#(
   parameter int LANE_W = 64
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_i,
   input  logic [2:0]        in_j,
   input  logic [LANE_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_index,
   output logic [LANE_W-1:0] out_data,
   output logic              done,
   output logic              err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

   state_t             state, state_nxt;
   logic [LANE_W-1:0]  lanes [LANES];
   logic [LANES-1:0]   filled;
   logic [LANES-1:0]   wr_mask;
   logic [IDX_W-1:0]   cnt;
   logic [IDX_W-1:0]   wr_idx;
   logic               wr_legal;
   logic               accept;
   logic               wr;

   ij_to_index u_map (
      .i     (in_i),
      .j     (in_j),
      .idx   (wr_idx),
      .legal (wr_legal)
   );

   assign accept    = in_valid && (state == FILL);
   assign wr        = accept && wr_legal;
   assign wr_mask   = LANES'(1) << wr_idx;
   assign out_index = cnt;
   assign out_data  = lanes[cnt];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FILL;
      else     state <= state_nxt;
   end

   // Next state and handshake outputs; drain starts once the bitmap would become full
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      done      = 1'b0;
      case (state)
         FILL: begin
            in_ready = 1'b1;
            if (wr && ((filled | wr_mask) == '1)) state_nxt = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (out_ready && (cnt == LAST_IDX)) begin
               done      = 1'b1;
               state_nxt = FILL;
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   // Bitmap and drain counter; the final handshake clears both for the next frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filled <= '0;
         cnt    <= '0;
      end else if (state == FILL) begin
         if (wr) filled <= filled | wr_mask;
      end else if (out_ready) begin
         if (cnt == LAST_IDX) begin
            cnt    <= '0;
            filled <= '0;
         end else begin
            cnt <= cnt + IDX_W'(1);
         end
      end
   end

   // Lane storage is deliberately left unreset
   always_ff @(posedge clk) begin
      if (wr) lanes[wr_idx] <= in_data;
   end

`ifdef LANE_SCATTER_ERR_EN
   logic err_q;

   // Sticky flag: an accepted write that is off-grid or lands on an already-filled lane
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                      err_q <= 1'b0;
      else if (accept && (!wr_legal || filled[wr_idx])) err_q <= 1'b1;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lane_scatter_gather.sv
// Scoreboard bench for lane_scatter_gather: model lanes pushed at fill time, compared as the DUT drains.
module tb_lane_scatter_gather;

   localparam int LANE_W = 64;
`ifdef LANE_SCATTER_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_i;
   logic [2:0]        in_j;
   logic [LANE_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [4:0]        out_index;
   logic [LANE_W-1:0] out_data;
   logic              done;
   logic              err;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [LANE_W-1:0] model [25];
   bit   [24:0]       filled_m;
   logic              exp_err;

   logic [4:0]        exp_idx_q [$];
   logic [LANE_W-1:0] exp_data_q [$];
   logic [4:0]        obs_idx_q [$];
   logic [LANE_W-1:0] obs_data_q [$];
   logic              obs_done_q [$];
   int                stall_changes;
   int                inready_high;
   int                drain_cycles;
   int                perm [25];

   lane_scatter_gather #(.LANE_W(LANE_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_i      (in_i),
      .in_j      (in_j),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_index (out_index),
      .out_data  (out_data),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   function automatic int idx_of(input int i, input int j);
      return 5 * ((j + 2) % 5) + ((i + 2) % 5);
   endfunction

   function automatic int i_of(input int k);
      return ((k % 5) + 3) % 5;
   endfunction

   function automatic int j_of(input int k);
      return ((k / 5) + 3) % 5;
   endfunction

   // Drives one write at a negedge and updates the lane model
   task automatic write_lane(input int i, input int j, input logic [LANE_W-1:0] d, output logic rdy);
      int k;
      @(negedge clk);
      in_valid = 1'b1;
      in_i     = i[2:0];
      in_j     = j[2:0];
      in_data  = d;
      #1 rdy = in_ready;
      if (i < 5 && j < 5) begin
         k = idx_of(i, j);
         if (filled_m[k] && ERR_EN) exp_err = 1'b1;
         model[k]    = d;
         filled_m[k] = 1'b1;
      end else if (ERR_EN) begin
         exp_err = 1'b1;
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      #1;
   endtask

   task automatic push_expected();
      for (int k = 0; k < 25; k++) begin
         exp_idx_q.push_back(5'(k));
         exp_data_q.push_back(model[k]);
      end
      filled_m = '0;
   endtask

   task automatic shuffle(input int n);
      int r, t;
      for (int k = 0; k < n; k++) perm[k] = k;
      for (int k = n - 1; k > 0; k--) begin
         r = $urandom_range(k, 0);
         t = perm[k]; perm[k] = perm[r]; perm[r] = t;
      end
   endtask

   // mode 0: always ready; mode 1: out_ready pattern 1,0,0,1
   task automatic collect(input int mode, input int budget);
      logic             prev_stall;
      logic [4:0]       pidx;
      logic [LANE_W-1:0] pdata;
      obs_idx_q.delete(); obs_data_q.delete(); obs_done_q.delete();
      stall_changes = 0; inready_high = 0; drain_cycles = 0;
      prev_stall = 1'b0; pidx = '0; pdata = '0;
      for (int c = 0; c < budget && obs_idx_q.size() < 25; c++) begin
         @(negedge clk);
         out_ready = (mode == 0) ? 1'b1 : ((c % 4) == 0 || (c % 4) == 3);
         #1;
         if (out_valid) begin
            drain_cycles++;
            if (in_ready) inready_high++;
            if (prev_stall && (out_index !== pidx || out_data !== pdata)) stall_changes++;
            if (out_ready) begin
               obs_idx_q.push_back(out_index);
               obs_data_q.push_back(out_data);
               obs_done_q.push_back(done);
            end
            prev_stall = !out_ready;
            pidx       = out_index;
            pdata      = out_data;
         end
      end
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #2;
      exp_err = 1'b0;
      filled_m = '0;
      exp_idx_q.delete(); exp_data_q.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic rdy;
      #12;
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_state: got rdy=%b vld=%b done=%b err=%b expected 1 0 0 0",
                  in_ready, out_valid, done, err);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 25; k++) write_lane(i_of(k), j_of(k), {$urandom, $urandom}, rdy);
      write_lane(i_of(0), j_of(0), 64'h0, rdy);
      idle();
      tests_run++;
      if (err !== exp_err) begin
         tests_failed++;
         $display("[TB] FAIL reset_pre_err: got %b expected %b", err, exp_err);
      end
      @(negedge clk);
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_drain: got vld=%b rdy=%b err=%b expected 0 1 0",
                  out_valid, in_ready, err);
      end
      out_ready = 1'b0;
      exp_err = 1'b0;
      filled_m = '0;
      @(negedge clk);
      rst = 1'b0;
      shuffle(25);
      for (int k = 0; k < 24; k++)
         write_lane(i_of(perm[k]), j_of(perm[k]), {$urandom, $urandom}, rdy);
      idle();
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_bitmap_cleared: got out_valid=%b expected 0", out_valid);
      end
      write_lane(i_of(perm[24]), j_of(perm[24]), {$urandom, $urandom}, rdy);
      idle();
      push_expected();
      collect(0, 60);
      tests_run++;
      if (obs_idx_q.size() != 25) begin
         tests_failed++;
         $display("[TB] FAIL reset_drain_count: got %0d expected 25", obs_idx_q.size());
      end
      while (exp_idx_q.size() > 0 && obs_idx_q.size() > 0) begin
         logic [4:0] ei, oi; logic [LANE_W-1:0] ed, od; logic odn;
         ei = exp_idx_q.pop_front(); ed = exp_data_q.pop_front();
         oi = obs_idx_q.pop_front(); od = obs_data_q.pop_front(); odn = obs_done_q.pop_front();
         tests_run++;
         if (oi !== ei || od !== ed || odn !== (ei == 5'd24)) begin
            tests_failed++;
            $display("[TB] FAIL reset_lane: got idx=%0d data=%h done=%b expected idx=%0d data=%h done=%b",
                     oi, od, odn, ei, ed, ei == 5'd24);
         end
      end
      exp_idx_q.delete(); exp_data_q.delete();
   endtask

   task automatic test_linear();
      logic rdy;
      for (int k = 0; k < 24; k++) write_lane(i_of(k), j_of(k), LANE_W'(k), rdy);
      write_lane(i_of(24), j_of(24), LANE_W'(24), rdy);
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL linear_early_valid: got %b expected 0", out_valid);
      end
      idle();
      tests_run++;
      if (out_valid !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL linear_latency: got out_valid=%b expected 1", out_valid);
      end
      push_expected();
      collect(0, 60);
      tests_run++;
      if (obs_idx_q.size() != 25 || drain_cycles != 25) begin
         tests_failed++;
         $display("[TB] FAIL linear_drain_cycles: got lanes=%0d cycles=%0d expected 25 25",
                  obs_idx_q.size(), drain_cycles);
      end
      while (exp_idx_q.size() > 0 && obs_idx_q.size() > 0) begin
         logic [4:0] ei, oi; logic [LANE_W-1:0] ed, od; logic odn;
         ei = exp_idx_q.pop_front(); ed = exp_data_q.pop_front();
         oi = obs_idx_q.pop_front(); od = obs_data_q.pop_front(); odn = obs_done_q.pop_front();
         tests_run++;
         if (oi !== ei || od !== ed || odn !== (ei == 5'd24)) begin
            tests_failed++;
            $display("[TB] FAIL linear_lane: got idx=%0d data=%h done=%b expected idx=%0d data=%h done=%b",
                     oi, od, odn, ei, ed, ei == 5'd24);
         end
      end
      exp_idx_q.delete(); exp_data_q.delete();
   endtask

   task automatic test_duplicates();
      logic rdy;
      shuffle(24);
      write_lane(2, 2, 64'hAAAA_AAAA_AAAA_AAAA, rdy);
      for (int k = 0; k < 12; k++) write_lane(i_of(perm[k]), j_of(perm[k]), {$urandom, $urandom}, rdy);
      write_lane(2, 2, 64'hBBBB_BBBB_BBBB_BBBB, rdy);
      for (int k = 12; k < 23; k++) write_lane(i_of(perm[k]), j_of(perm[k]), {$urandom, $urandom}, rdy);
      idle();
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL dup_early_drain: got out_valid=%b expected 0", out_valid);
      end
      write_lane(i_of(perm[23]), j_of(perm[23]), {$urandom, $urandom}, rdy);
      idle();
      tests_run++;
      if (out_valid !== 1'b1 || err !== exp_err) begin
         tests_failed++;
         $display("[TB] FAIL dup_drain_start: got vld=%b err=%b expected 1 %b", out_valid, err, exp_err);
      end
      push_expected();
      collect(0, 60);
      tests_run++;
      if (obs_idx_q.size() != 25) begin
         tests_failed++;
         $display("[TB] FAIL dup_drain_count: got %0d expected 25", obs_idx_q.size());
      end
      while (exp_idx_q.size() > 0 && obs_idx_q.size() > 0) begin
         logic [4:0] ei, oi; logic [LANE_W-1:0] ed, od; logic odn;
         ei = exp_idx_q.pop_front(); ed = exp_data_q.pop_front();
         oi = obs_idx_q.pop_front(); od = obs_data_q.pop_front(); odn = obs_done_q.pop_front();
         tests_run++;
         if (oi !== ei || od !== ed || odn !== (ei == 5'd24)) begin
            tests_failed++;
            $display("[TB] FAIL dup_lane: got idx=%0d data=%h done=%b expected idx=%0d data=%h done=%b",
                     oi, od, odn, ei, ed, ei == 5'd24);
         end
      end
      exp_idx_q.delete(); exp_data_q.delete();
   endtask

   task automatic test_backpressure();
      logic rdy;
      for (int k = 0; k < 25; k++) write_lane(i_of(k), j_of(k), {$urandom, $urandom}, rdy);
      idle();
      push_expected();
      collect(1, 200);
      tests_run++;
      if (stall_changes != 0 || inready_high != 0 || obs_idx_q.size() != 25) begin
         tests_failed++;
         $display("[TB] FAIL bp_stall: got changes=%0d in_ready_hi=%0d lanes=%0d expected 0 0 25",
                  stall_changes, inready_high, obs_idx_q.size());
      end
      while (exp_idx_q.size() > 0 && obs_idx_q.size() > 0) begin
         logic [4:0] ei, oi; logic [LANE_W-1:0] ed, od; logic odn;
         ei = exp_idx_q.pop_front(); ed = exp_data_q.pop_front();
         oi = obs_idx_q.pop_front(); od = obs_data_q.pop_front(); odn = obs_done_q.pop_front();
         tests_run++;
         if (oi !== ei || od !== ed || odn !== (ei == 5'd24)) begin
            tests_failed++;
            $display("[TB] FAIL bp_lane: got idx=%0d data=%h done=%b expected idx=%0d data=%h done=%b",
                     oi, od, odn, ei, ed, ei == 5'd24);
         end
      end
      exp_idx_q.delete(); exp_data_q.delete();
   endtask

   task automatic test_illegal();
      logic rdy;
      do_reset();
      for (int k = 0; k < 25; k++)
         if (k != 22) write_lane(i_of(k), j_of(k), {$urandom, $urandom}, rdy);
      write_lane(5, 0, 64'hDEAD_DEAD_DEAD_DEAD, rdy);
      write_lane(0, 7, 64'hBEEF_BEEF_BEEF_BEEF, rdy);
      idle();
      tests_run++;
      if (out_valid !== 1'b0 || err !== exp_err) begin
         tests_failed++;
         $display("[TB] FAIL illegal_dropped: got vld=%b err=%b expected 0 %b", out_valid, err, exp_err);
      end
      idle();
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL illegal_no_drain: got out_valid=%b expected 0", out_valid);
      end
      write_lane(i_of(22), j_of(22), {$urandom, $urandom}, rdy);
      idle();
      push_expected();
      collect(0, 60);
      tests_run++;
      if (obs_idx_q.size() != 25 || err !== exp_err) begin
         tests_failed++;
         $display("[TB] FAIL illegal_drain: got lanes=%0d err=%b expected 25 %b",
                  obs_idx_q.size(), err, exp_err);
      end
      while (exp_idx_q.size() > 0 && obs_idx_q.size() > 0) begin
         logic [4:0] ei, oi; logic [LANE_W-1:0] ed, od; logic odn;
         ei = exp_idx_q.pop_front(); ed = exp_data_q.pop_front();
         oi = obs_idx_q.pop_front(); od = obs_data_q.pop_front(); odn = obs_done_q.pop_front();
         tests_run++;
         if (oi !== ei || od !== ed || odn !== (ei == 5'd24)) begin
            tests_failed++;
            $display("[TB] FAIL illegal_lane: got idx=%0d data=%h done=%b expected idx=%0d data=%h done=%b",
                     oi, od, odn, ei, ed, ei == 5'd24);
         end
      end
      exp_idx_q.delete(); exp_data_q.delete();
      do_reset();
      tests_run++;
      if (err !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL illegal_err_cleared: got %b expected 0", err);
      end
   endtask

   task automatic test_back_to_back();
      logic rdy;
      for (int k = 0; k < 25; k++) write_lane(i_of(k), j_of(k), {$urandom, $urandom}, rdy);
      idle();
      push_expected();
      collect(0, 60);
      tests_run++;
      if (obs_idx_q.size() != 25) begin
         tests_failed++;
         $display("[TB] FAIL b2b_first_count: got %0d expected 25", obs_idx_q.size());
      end
      while (exp_idx_q.size() > 0 && obs_idx_q.size() > 0) begin
         logic [4:0] ei, oi; logic [LANE_W-1:0] ed, od; logic odn;
         ei = exp_idx_q.pop_front(); ed = exp_data_q.pop_front();
         oi = obs_idx_q.pop_front(); od = obs_data_q.pop_front(); odn = obs_done_q.pop_front();
         tests_run++;
         if (oi !== ei || od !== ed || odn !== (ei == 5'd24)) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first_lane: got idx=%0d data=%h done=%b expected idx=%0d data=%h",
                     oi, od, odn, ei, ed);
         end
      end
      exp_idx_q.delete(); exp_data_q.delete();
      shuffle(25);
      write_lane(i_of(perm[0]), j_of(perm[0]), {$urandom, $urandom}, rdy);
      tests_run++;
      if (rdy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL b2b_first_write: got in_ready=%b expected 1", rdy);
      end
      for (int k = 1; k < 25; k++) write_lane(i_of(perm[k]), j_of(perm[k]), {$urandom, $urandom}, rdy);
      idle();
      push_expected();
      collect(0, 60);
      tests_run++;
      if (obs_idx_q.size() != 25) begin
         tests_failed++;
         $display("[TB] FAIL b2b_second_count: got %0d expected 25", obs_idx_q.size());
      end
      while (exp_idx_q.size() > 0 && obs_idx_q.size() > 0) begin
         logic [4:0] ei, oi; logic [LANE_W-1:0] ed, od; logic odn;
         ei = exp_idx_q.pop_front(); ed = exp_data_q.pop_front();
         oi = obs_idx_q.pop_front(); od = obs_data_q.pop_front(); odn = obs_done_q.pop_front();
         tests_run++;
         if (oi !== ei || od !== ed || odn !== (ei == 5'd24)) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second_lane: got idx=%0d data=%h done=%b expected idx=%0d data=%h",
                     oi, od, odn, ei, ed);
         end
      end
      exp_idx_q.delete(); exp_data_q.delete();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_i      = '0;
      in_j      = '0;
      in_data   = '0;
      out_ready = 1'b0;
      exp_err   = 1'b0;
      filled_m  = '0;
      test_reset();
      test_linear();
      test_duplicates();
      test_backpressure();
      test_illegal();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/lane_scatter_gather.md
Name: lane_scatter_gather

Overview:
- Collects the 25 lanes of a 5x5 state.
- Each lane arrives addressed by grid coordinates (i, j) in any order.
- Each lane is stored at its linear index. When all 25 lanes are present, the block streams them out in linear order 0..24.
- Performs the coordinate-to-index conversion, the inverse of the team's index-to-(i,j) mapping. It sits between the coordinate-domain round logic and the linear-order lane consumer.

Parameters:
- LANE_W, 64, lane data width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  a lane write is offered.
- in_ready  out  1  block accepts a write this cycle.
- in_i  in  3  lane x coordinate; legal range 0..4.
- in_j  in  3  lane y coordinate; legal range 0..4.
- in_data  in  LANE_W  lane payload.
- out_valid  out  1  output lane is valid.
- out_ready  in  1  downstream accepts the output lane.
- out_index  out  5  linear index of the output lane, 0..24.
- out_data  out  LANE_W  output lane payload.
- done  out  1  one-cycle pulse on acceptance of lane 24.
- err  out  1  sticky error flag; only active with the optional feature.

Behaviour:
- Index map: idx = 5*((j+2) mod 5) + ((i+2) mod 5).
  - Examples: (3,3)->0, (4,3)->1, (0,3)->2, (3,4)->5, (2,2)->24.
- Storage: 25 x LANE_W register buffer plus a 25-bit filled bitmap.
- State machine with two states, FILL and DRAIN.
- FILL state:
  - in_ready=1 and out_valid=0.
  - Write rule: on in_valid&&in_ready with legal coordinates, buf[idx] <= in_data and bitmap[idx] <= 1.
  - Duplicate coordinates overwrite the lane; the bitmap bit stays unchanged.
  - Illegal coordinates (i>4 or j>4) are accepted and dropped; the bitmap is unchanged.
  - When the write makes the bitmap all-ones, the next state is DRAIN and cnt is 0.
  - Latency: out_valid rises on the cycle after the 25th distinct lane is accepted.
- DRAIN state:
  - in_ready=0 and out_valid=1.
  - out_index=cnt and out_data=buf[cnt]; both are combinational from registers.
  - Outputs are held stable while out_ready=0.
  - On out_ready: cnt increments.
  - At cnt==24 with out_ready: done=1 that cycle, then next state is FILL, the bitmap clears and cnt returns to 0.
- A new fill may begin in the cycle after done; no bubble beyond that.
- Reset values, applied immediately on rst: state FILL, bitmap 0, cnt 0, in_ready 1, out_valid 0, done 0, err 0.
  - Buffer contents are not reset and are don't-care.
  - Reset mid-FILL or mid-DRAIN discards all collected lanes.
- Width rules: mod-5 arithmetic uses 3-bit operands; idx and cnt are 5 bits.

Optional Feature:
- Macro: LANE_SCATTER_ERR_EN.
- Defined:
  - err sets on an accepted write with illegal coordinates or to an already-filled lane.
  - err stays set until rst.
  - Data handling is identical to the undefined case.
- Undefined: err is tied to 0 and no checking logic is present.

Decomposition:
- Package lane_scatter_pkg holds:
  - GRID=5, LANES=25 and IDX_W=5.
  - The state enum {FILL, DRAIN}.
  - Function ij_to_idx(i,j).
- One combinational sub-module, ij_to_index: (i, j) in, idx and legal out. It is instantiated once on the write path and reused by the checker.

Test Plan:
- Reset: assert rst mid-DRAIN -> out_valid=0, in_ready=1, err=0 immediately; a subsequent full fill drains lanes 0..24 correctly.
- Linear-order fill: write (i,j) in idx order with data=idx, out_ready=1 -> out_valid one cycle after last write; out_index/out_data 0..24 on consecutive cycles; done with index 24.
- Random-order fill with duplicates: overwrite (2,2) twice, data A then B -> drain continues only after all 25 distinct lanes; lane 24 = B.
- Backpressure: out_ready toggling 1,0,0,1 -> out_index/out_data stable during stalls; no lane skipped or repeated; in_ready=0 throughout DRAIN.
- Illegal coordinates: write (5,0) and (0,7) -> no bitmap change and no drain start; with LANE_SCATTER_ERR_EN, err=1 next cycle and sticky until rst.
- Back-to-back frames: begin the second fill the cycle after done -> first write accepted; second drain correct.
